// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 icode constants, register sentinels and writeback state type
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] RSP_IDX = 4'h4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_t;

endpackage

// File: rtl/y86_wb_dst_decode.sv
// rtl/y86_wb_dst_decode.sv - combinational icode/cnd/rA/rB to destE/destM decoder
module y86_wb_dst_decode
  import y86_pkg::I_RRMOVQ, y86_pkg::I_IRMOVQ, y86_pkg::I_MRMOVQ, y86_pkg::I_OPQ,
         y86_pkg::I_CALL, y86_pkg::I_RET, y86_pkg::I_PUSHQ, y86_pkg::I_POPQ;
#(
  parameter logic [3:0] RNONE   = 4'hF,
  parameter logic [3:0] RSP_IDX = 4'h4
) (
  input  logic [3:0] icode,
  input  logic       cnd,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  output logic [3:0] dE,
  output logic [3:0] dM
);

  always_comb begin
    dE = RNONE;
    dM = RNONE;
    case (icode)
      I_RRMOVQ: dE = cnd ? rB : RNONE;
      I_IRMOVQ,
      I_OPQ:    dE = rB;
      I_MRMOVQ: dM = rA;
      I_CALL,
      I_RET,
      I_PUSHQ:  dE = RSP_IDX;
      I_POPQ: begin
        dE = RSP_IDX;
        dM = rA;
      end
      default: begin
        dE = RNONE;
        dM = RNONE;
      end
    endcase
  end

endmodule

// File: rtl/y86_regfile_wb.sv
// rtl/y86_regfile_wb.sv - Y86-64 writeback stage with register file, bypassed read ports and halt FSM
module y86_regfile_wb
  import y86_pkg::I_HALT, y86_pkg::wb_state_t, y86_pkg::RUN, y86_pkg::HALTED;
#(
  parameter int          DATA_W  = 64,
  parameter int          NREG    = 15,
  parameter logic [3:0]  RNONE   = 4'hF,
  parameter logic [3:0]  RSP_IDX = 4'h4,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic              wb_stall,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] rdA,
  output logic [DATA_W-1:0] rdB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic              halted,
  output logic [31:0]       commit_cnt
);

  logic [DATA_W-1:0] regs [NREG];
  logic [3:0]        dE;
  logic [3:0]        dM;
  logic              commit;
  wb_state_t         state_q;
  wb_state_t         state_d;

  y86_wb_dst_decode #(
    .RNONE   (RNONE),
    .RSP_IDX (RSP_IDX)
  ) u_dst_decode (
    .icode (icode),
    .cnd   (cnd),
    .rA    (rA),
    .rB    (rB),
    .dE    (dE),
    .dM    (dM)
  );

  assign commit = wb_valid && !wb_stall && (state_q == RUN);
  assign halted = (state_q == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (commit && icode == I_HALT) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // M port checked first so popq %rsp keeps the loaded value, not the incremented pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else if (commit) begin
      for (int i = 0; i < NREG; i++) begin
        if (dM != RNONE && dM == 4'(i)) begin
          regs[i] <= valM;
        end else if (dE != RNONE && dE == 4'(i)) begin
          regs[i] <= valE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dstE       <= RNONE;
      dstM       <= RNONE;
      commit_cnt <= '0;
    end else if (commit) begin
      dstE       <= dE;
      dstM       <= dM;
      commit_cnt <= commit_cnt + 32'd1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] src);
    logic [DATA_W-1:0] r;
    r = '0;
    if (src != RNONE && int'(src) < NREG) begin
      if (BYPASS && commit && src == dM) begin
        r = valM;
      end else if (BYPASS && commit && src == dE) begin
        r = valE;
      end else begin
        r = regs[src];
      end
    end
    return r;
  endfunction

  always_comb begin
    rdA = read_port(srcA);
    rdB = read_port(srcB);
  end

endmodule

// File: tb/tb_y86_regfile_wb.sv
// tb/tb_y86_regfile_wb.sv - directed self-checking bench for y86_regfile_wb (bypass and non-bypass)
module tb_y86_regfile_wb;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_stall;
  logic [3:0]  icode;
  logic        cnd;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valE;
  logic [63:0] valM;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] rdA, rdB, rdA_nb, rdB_nb;
  logic [3:0]  dstE, dstM, dstE_nb, dstM_nb;
  logic        halted, halted_nb;
  logic [31:0] commit_cnt, commit_cnt_nb;

  int n_assert = 0;
  int n_fail   = 0;

  y86_regfile_wb #(.DATA_W(64), .NREG(15), .RNONE(4'hF), .RSP_IDX(4'h4), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_stall(wb_stall),
    .icode(icode), .cnd(cnd), .rA(rA), .rB(rB), .valE(valE), .valM(valM),
    .srcA(srcA), .srcB(srcB), .rdA(rdA), .rdB(rdB), .dstE(dstE), .dstM(dstM),
    .halted(halted), .commit_cnt(commit_cnt)
  );

  y86_regfile_wb #(.DATA_W(64), .NREG(15), .RNONE(4'hF), .RSP_IDX(4'h4), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_stall(wb_stall),
    .icode(icode), .cnd(cnd), .rA(rA), .rB(rB), .valE(valE), .valM(valM),
    .srcA(srcA), .srcB(srcB), .rdA(rdA_nb), .rdB(rdB_nb), .dstE(dstE_nb), .dstM(dstM_nb),
    .halted(halted_nb), .commit_cnt(commit_cnt_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; wb_stall = 1'b0; icode = 4'h1; cnd = 1'b0;
    rA = 4'hF; rB = 4'hF; valE = '0; valM = '0; srcA = 4'd3; srcB = 4'd14;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdA", rdA, 64'd3);
    chk("reset_rdB", rdB, 64'd14);
    chk("reset_dstE", 64'(dstE), 64'hF);
    chk("reset_dstM", 64'(dstM), 64'hF);
    chk("reset_cnt", 64'(commit_cnt), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);
    #3 rst_n = 1'b1;

    // irmovq $0xDEAD, %rdx
    icode = 4'h3; rA = 4'hF; rB = 4'd2; valE = 64'hDEAD; wb_valid = 1'b1; srcA = 4'd2; srcB = 4'hF;
    #1;
    chk("irmovq_bypass_rdA", rdA, 64'hDEAD);
    chk("irmovq_nobypass_rdA", rdA_nb, 64'd2);
    chk("rnone_read_rdB", rdB, 64'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("irmovq_dstE", 64'(dstE), 64'd2);
    chk("irmovq_dstM", 64'(dstM), 64'hF);
    chk("irmovq_cnt", 64'(commit_cnt), 64'd1);
    chk("irmovq_nobypass_after", rdA_nb, 64'hDEAD);

    // popq %rsp: valM must win over valE
    icode = 4'hB; rA = 4'd4; rB = 4'hF; valE = 64'h100; valM = 64'h55; wb_valid = 1'b1; srcA = 4'd4; srcB = 4'd4;
    #1;
    chk("popq_bypass_rdA", rdA, 64'h55);
    chk("popq_nobypass_rdB", rdB_nb, 64'd4);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("popq_stored", rdA, 64'h55);
    chk("popq_stored_nb", rdA_nb, 64'h55);
    chk("popq_dstE", 64'(dstE), 64'd4);
    chk("popq_dstM", 64'(dstM), 64'd4);
    chk("popq_cnt", 64'(commit_cnt), 64'd2);

    // cmovXX not taken, then taken
    icode = 4'h2; rA = 4'd0; rB = 4'd5; valE = 64'd7; cnd = 1'b0; wb_valid = 1'b1; srcA = 4'd5;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("cmov_nt_reg5", rdA, 64'd5);
    chk("cmov_nt_dstE", 64'(dstE), 64'hF);
    chk("cmov_nt_cnt", 64'(commit_cnt), 64'd3);
    cnd = 1'b1; wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("cmov_t_reg5", rdA, 64'd7);
    chk("cmov_t_dstE", 64'(dstE), 64'd5);
    chk("cmov_t_cnt", 64'(commit_cnt), 64'd4);

    // stalled OPq, then released
    icode = 4'h6; rA = 4'd0; rB = 4'd1; valE = 64'd9; cnd = 1'b0; wb_valid = 1'b1; wb_stall = 1'b1; srcA = 4'd1;
    #1;
    chk("stall_no_bypass", rdA, 64'd1);
    tick();
    chk("stall_reg1", rdA, 64'd1);
    chk("stall_cnt", 64'(commit_cnt), 64'd4);
    chk("stall_dstE_hold", 64'(dstE), 64'd5);
    wb_stall = 1'b0;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("release_reg1", rdA, 64'd9);
    chk("release_dstE", 64'(dstE), 64'd1);
    chk("release_cnt", 64'(commit_cnt), 64'd5);

    // mrmovq into %r14 exercises the M-only path
    icode = 4'h5; rA = 4'd14; rB = 4'd3; valE = 64'h1234; valM = 64'hABC; wb_valid = 1'b1; srcA = 4'd14; srcB = 4'd3;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("mrmovq_reg14", rdA, 64'hABC);
    chk("mrmovq_reg3_untouched", rdB, 64'd3);
    chk("mrmovq_dstE", 64'(dstE), 64'hF);
    chk("mrmovq_dstM", 64'(dstM), 64'd14);

    // halt commits, then everything is frozen
    icode = 4'h0; rA = 4'hF; rB = 4'hF; wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0;
    #1;
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_cnt", 64'(commit_cnt), 64'd7);
    chk("halt_dstM", 64'(dstM), 64'hF);
    icode = 4'h3; rB = 4'd0; valE = 64'h77; wb_valid = 1'b1; srcA = 4'd0; srcB = 4'd9;
    #1;
    chk("halted_no_bypass", rdA, 64'd0);
    tick();
    chk("halted_reg0", rdA, 64'd0);
    chk("halted_reg9_read", rdB, 64'd9);
    chk("halted_cnt_frozen", 64'(commit_cnt), 64'd7);
    chk("halted_stays", 64'(halted), 64'd1);

    // asynchronous reset mid-cycle
    srcA = 4'd1; srcB = 4'd14;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_reg1", rdA, 64'd1);
    chk("async_rst_reg14", rdB, 64'd14);
    chk("async_rst_halted", 64'(halted), 64'd0);
    chk("async_rst_cnt", 64'(commit_cnt), 64'd0);
    chk("async_rst_dstM", 64'(dstM), 64'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/y86_regfile_wb.md
Name: y86_regfile_wb

Overview:
- Parametrised Y86-64 writeback stage with an integrated register file.
- Decodes each retiring instruction into destE/destM, commits valE/valM on the clock edge, and serves two combinational read ports to decode.
- Generalises the single-port SEQ writeback with:
  - a configurable data width and register count
  - optional write-to-read bypass
  - explicit valid/stall qualification
  - a halt state machine that freezes architectural state

Parameters:
DATA_W, 64, register/data width in bits
NREG, 15, number of architectural registers (indices 0..NREG-1; NREG <= 15)
RNONE, 4'hF, register index meaning "no register"
RSP_IDX, 4, stack pointer index used by call/ret/pushq/popq
BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read ports return stored value only

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wb_valid  in  1  instruction present in writeback this cycle
wb_stall  in  1  hold; suppresses commit even when wb_valid=1
icode  in  4  instruction code
cnd  in  1  condition flag (cmovXX)
rA  in  4  rA field
rB  in  4  rB field
valE  in  DATA_W  ALU result
valM  in  DATA_W  memory read data
srcA  in  4  read port A index
srcB  in  4  read port B index
rdA  out  DATA_W  read data A
rdB  out  DATA_W  read data B
dstE  out  4  destE of last committed instruction (registered)
dstM  out  4  destM of last committed instruction (registered)
halted  out  1  halt state reached
commit_cnt  out  32  count of committed instructions

Behaviour:
- Reset (async, rst_n=0):
  - register[i] = i for i in 0..NREG-1
  - dstE = dstM = RNONE
  - halted = 0
  - commit_cnt = 0
  - FSM -> RUN
- Commit condition: commit = wb_valid & ~wb_stall & (state==RUN).
- Destination decode (combinational):
  - cmovXX (2): dE = cnd ? rB : RNONE
  - irmovq (3): dE = rB
  - OPq (6): dE = rB
  - mrmovq (5): dM = rA
  - call (8), ret (9), pushq (A): dE = RSP_IDX
  - popq (B): dE = RSP_IDX, dM = rA
  - All other icodes (0, 1, 4, 7, C-F): dE = dM = RNONE.
- Write on commit at rising edge:
  - dE != RNONE and dE < NREG: reg[dE] <= valE
  - dM likewise: reg[dM] <= valM
  - Indices >= NREG (other than RNONE) are silently dropped.
- Same-register conflict (dE == dM, e.g. popq %rsp): valM wins; valE is discarded.
- Registered outputs on commit:
  - dstE <= dE, dstM <= dM, commit_cnt += 1, wrapping at 2^32-1 -> 0.
  - Without a commit, dstE/dstM/commit_cnt hold.
- FSM, 2 states:
  - RUN -> HALTED when commit and icode == 0; halted <= 1 on that edge.
  - HALTED is absorbing until reset. The halt instruction itself counts as committed.
  - In HALTED no writes occur; read ports remain functional.
- Read ports:
  - Index RNONE or >= NREG returns 0.
  - BYPASS=1 and commit this cycle: a src matching dM returns valM; else a src matching dE returns valE; else the stored value. Priority is M over E, matching the write rule.
  - BYPASS=0: stored value only, so new data is visible the cycle after the edge.
- Latency: 1 cycle from commit to stored state; 0 cycles through bypass.
- Reset mid-operation: asynchronous clear takes effect immediately; a write in progress that cycle is lost.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_JXX, I_CALL, I_RET, I_PUSHQ, I_POPQ)
  - RNONE and RSP_IDX
  - the wb_state_t enum (RUN, HALTED)
- One natural sub-module: y86_wb_dst_decode, a combinational icode/cnd/rA/rB -> dE/dM decoder reusable by the PIPE hazard logic.

Test Plan:
- Reset: rst_n low 2 cycles -> rdA(srcA=3) = 3, rdB(srcB=14) = 14, dstE = dstM = F, commit_cnt = 0, halted = 0.
- irmovq rB=2, valE=0xDEAD, wb_valid=1:
  - BYPASS=1: rdA(srcA=2) = 0xDEAD in the same cycle.
  - BYPASS=0: 0xDEAD only after the edge.
  - After the edge: dstE = 2, commit_cnt = 1.
- popq rA=4, valE=0x100, valM=0x55 -> reg[4] = 0x55 after the edge; same-cycle bypass read of 4 = 0x55; dstE = dstM = 4.
- cmovXX rB=5, cnd=0, valE=7 -> reg[5] stays 5, dstE = F. Repeat with cnd=1 -> reg[5] = 7.
- wb_stall=1 with OPq rB=1, valE=9 -> reg[1] stays 1, commit_cnt unchanged; release the stall -> reg[1] = 9.
- halt commits (commit_cnt increments, halted = 1) -> subsequent irmovq rB=0, valE=0x77 ignored: reg[0] stays 0, commit_cnt frozen. Assert rst_n=0 mid-cycle -> immediate return to reset values.
